// File: rtl/frac_div_pkg.sv
// Shared types and constants for the fractional-N divide-ratio controller.
package frac_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    PEND = 2'd3
  } state_e;

  // Integer ratios below this cannot be produced by the divider.
  localparam int MIN_INT = 2;

  // Dither LFSR: x^15 + x^14 + 1, Fibonacci form, feedback from bits 14 and 13.
  localparam int          LFSR_W    = 15;
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

endpackage

// File: rtl/frac_div_lfsr.sv
// Dither source for the fractional accumulator; advances one position per step.
module frac_div_lfsr
  import frac_div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic bit_out
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Shift in the XOR of the tapped bits when stepped.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // LFSR register, restarts from the seed on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_out = lfsr_q[0];

endmodule

// File: rtl/frac_div_ctrl.sv
// Fractional-N divide-ratio controller: a first-order accumulator turns N + K/2^FRAC_W
// into a per-division-cycle integer ratio of N or N+1.
// Build option FRAC_DIV_DITHER_EN adds an LFSR bit as carry-in to the accumulator.
//
// state | meaning
// IDLE  | stopped, ratio invalid; accepts config, holds it until enable is high
// LOAD  | one cycle: shadow config becomes active, accumulator cleared, ratio = N
// RUN   | accumulating on div_done; accepts a new config into the shadow
// PEND  | new config waiting; swapped in at the next div_done
module frac_div_ctrl
  import frac_div_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              div_done,
  output logic [INT_W:0]    ratio,
  output logic              ratio_valid,
  output logic              cfg_err
);

  state_e            state_q, state_d;
  logic              alive_q, alive_d;
  logic              held_q, held_d;
  logic [INT_W-1:0]  sh_n_q, sh_n_d;
  logic [FRAC_W-1:0] sh_k_q, sh_k_d;
  logic [INT_W-1:0]  act_n_q, act_n_d;
  logic [FRAC_W-1:0] act_k_q, act_k_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [INT_W:0]    ratio_q, ratio_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              cfg_acc;
  logic              cfg_good;
  logic              dither_bit;
  logic [INT_W-1:0]  n_sel;
  logic [FRAC_W-1:0] k_sel;
  logic [FRAC_W:0]   acc_sum;
  logic [INT_W:0]    ratio_next;

  // alive_q keeps cfg_ready low until the first edge after reset release.
  assign cfg_ready = alive_q && ((state_q == IDLE) || (state_q == RUN));
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign cfg_good  = cfg_acc && (cfg_int >= INT_W'(MIN_INT));

  // In PEND the div_done update already uses the shadow (new) config.
  assign n_sel      = (state_q == PEND) ? sh_n_q : act_n_q;
  assign k_sel      = (state_q == PEND) ? sh_k_q : act_k_q;
  assign acc_sum    = {1'b0, acc_q} + {1'b0, k_sel} + {{FRAC_W{1'b0}}, dither_bit};
  // One extra bit so N = 2^INT_W-1 plus carry yields 2^INT_W without wrapping.
  assign ratio_next = {1'b0, n_sel} + {{INT_W{1'b0}}, acc_sum[FRAC_W]};

`ifdef FRAC_DIV_DITHER_EN
  logic lfsr_step;

  assign lfsr_step = div_done && enable && ((state_q == RUN) || (state_q == PEND));

  frac_div_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .step    (lfsr_step),
    .bit_out (dither_bit)
  );
`else
  assign dither_bit = 1'b0;
`endif

  // Next-state, config handshake and accumulator update.
  always_comb begin
    state_d = state_q;
    alive_d = 1'b1;
    held_d  = held_q;
    sh_n_d  = sh_n_q;
    sh_k_d  = sh_k_q;
    act_n_d = act_n_q;
    act_k_d = act_k_q;
    acc_d   = acc_q;
    ratio_d = ratio_q;
    valid_d = valid_q;
    err_d   = cfg_acc && !cfg_good;

    if (!enable && (state_q != IDLE)) begin
      // Stop: pending config dropped, but a config accepted this very cycle is kept.
      state_d = IDLE;
      acc_d   = '0;
      ratio_d = '0;
      valid_d = 1'b0;
      held_d  = cfg_good;
      if (cfg_good) begin
        sh_n_d = cfg_int;
        sh_k_d = cfg_frac;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_good) begin
            sh_n_d = cfg_int;
            sh_k_d = cfg_frac;
          end
          if (enable && (held_q || cfg_good)) begin
            state_d = LOAD;
            held_d  = 1'b0;
          end else if (cfg_good) begin
            held_d = 1'b1;
          end
        end
        LOAD: begin
          act_n_d = sh_n_q;
          act_k_d = sh_k_q;
          acc_d   = '0;
          ratio_d = {1'b0, sh_n_q};
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (div_done) begin
            acc_d   = acc_sum[FRAC_W-1:0];
            ratio_d = ratio_next;
          end
          if (cfg_good) begin
            sh_n_d  = cfg_int;
            sh_k_d  = cfg_frac;
            state_d = PEND;
          end
        end
        PEND: begin
          if (div_done) begin
            act_n_d = sh_n_q;
            act_k_d = sh_k_q;
            acc_d   = acc_sum[FRAC_W-1:0];
            ratio_d = ratio_next;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards all configuration.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      held_q  <= 1'b0;
      sh_n_q  <= '0;
      sh_k_q  <= '0;
      act_n_q <= '0;
      act_k_q <= '0;
      acc_q   <= '0;
      ratio_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      held_q  <= held_d;
      sh_n_q  <= sh_n_d;
      sh_k_q  <= sh_k_d;
      act_n_q <= act_n_d;
      act_k_q <= act_k_d;
      acc_q   <= acc_d;
      ratio_q <= ratio_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ratio       = ratio_q;
  assign ratio_valid = valid_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_frac_div_ctrl.sv
// Scoreboard bench for frac_div_ctrl (INT_W=8, FRAC_W=16, no dither).
module tb_frac_div_ctrl;

  localparam int FRAC_MOD = 65536;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_PEND = 3;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        enable    = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_int   = '0;
  logic [15:0] cfg_frac  = '0;
  logic        div_done  = 1'b0;
  logic        cfg_ready;
  logic [8:0]  ratio;
  logic        ratio_valid;
  logic        cfg_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int exp_ratio_q[$];
  int err_cyc_q[$];

  // Reference model: abstract controller state plus integer arithmetic.
  int m_st    = M_IDLE;
  int m_alive = 0;
  int m_held  = 0;
  int m_sn    = 0;
  int m_sk    = 0;
  int m_an    = 0;
  int m_ak    = 0;
  int m_acc   = 0;

  frac_div_ctrl #(.INT_W(8), .FRAC_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_int     (cfg_int),
    .cfg_frac    (cfg_frac),
    .div_done    (div_done),
    .ratio       (ratio),
    .ratio_valid (ratio_valid),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_ready();
    return (m_alive != 0 && (m_st == M_IDLE || m_st == M_RUN)) ? 1 : 0;
  endfunction

  function automatic int m_valid();
    return (m_st == M_RUN || m_st == M_PEND) ? 1 : 0;
  endfunction

  // Advance one division cycle with the given ratio N and increment K.
  task automatic m_divide(input int n, input int k);
    int s;
    s = m_acc + k;
    exp_ratio_q.push_back(n + s / FRAC_MOD);
    m_acc = s % FRAC_MOD;
  endtask

  // Model reaction to the inputs present at the coming clock edge.
  task automatic m_update(input bit dd, input bit en, input bit cv, input int n, input int k);
    bit took;
    bit good;
    took = cv && (m_ready() != 0);
    good = took && (n >= 2);
    if (took && !good) err_cyc_q.push_back(cyc + 1);
    if (!en && m_st != M_IDLE) begin
      m_st   = M_IDLE;
      m_acc  = 0;
      m_held = good ? 1 : 0;
      if (good) begin m_sn = n; m_sk = k; end
    end else begin
      case (m_st)
        M_IDLE: begin
          if (good) begin m_sn = n; m_sk = k; m_held = 1; end
          if (en && m_held != 0) begin m_st = M_LOAD; m_held = 0; end
        end
        M_LOAD: begin
          m_an = m_sn; m_ak = m_sk; m_acc = 0;
          exp_ratio_q.push_back(m_an);
          m_st = M_RUN;
        end
        M_RUN: begin
          if (dd) m_divide(m_an, m_ak);
          if (good) begin m_sn = n; m_sk = k; m_st = M_PEND; end
        end
        default: begin
          if (dd) begin
            m_an = m_sn; m_ak = m_sk;
            m_divide(m_an, m_ak);
            m_st = M_RUN;
          end
        end
      endcase
    end
    m_alive = 1;
  endtask

  // One clock cycle of stimulus; called and returning at posedge+1.
  task automatic step(input bit dd, input bit en, input bit cv, input int n, input int k);
    div_done  = dd;
    enable    = en;
    cfg_valid = cv;
    cfg_int   = n[7:0];
    cfg_frac  = k[15:0];
    @(negedge clk);
    check("cfg_ready", int'(cfg_ready), m_ready());
    check("ratio_valid", int'(ratio_valid), m_valid());
    #1;
    m_update(dd, en, cv, n, k);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    div_done  = 1'b0;
    cfg_valid = 1'b0;
    rst       = 1'b0;
    #1;
    check("rst_ratio", int'(ratio), 0);
    check("rst_ratio_valid", int'(ratio_valid), 0);
    check("rst_cfg_ready", int'(cfg_ready), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    m_st = M_IDLE; m_alive = 0; m_held = 0;
    m_sn = 0; m_sk = 0; m_an = 0; m_ak = 0; m_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: a new ratio is presented when ratio_valid rises or after a counted div_done.
  bit last_valid = 1'b0;
  bit last_dd    = 1'b0;
  int last_ratio = 0;
  always @(negedge clk) begin
    bit exp_err;
    if (rst) begin
      if (ratio_valid && (!last_valid || last_dd)) begin
        if (exp_ratio_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ratio_unexpected: got %0d, expected no new ratio (t=%0t)", ratio, $time);
        end else begin
          check("ratio", int'(ratio), exp_ratio_q.pop_front());
        end
      end else if (ratio_valid && last_valid) begin
        check("ratio_hold", int'(ratio), last_ratio);
      end
      while (err_cyc_q.size() > 0 && err_cyc_q[0] < cyc) void'(err_cyc_q.pop_front());
      exp_err = (err_cyc_q.size() > 0 && err_cyc_q[0] == cyc);
      if (exp_err) void'(err_cyc_q.pop_front());
      if (cfg_err || exp_err) check("cfg_err", int'(cfg_err), int'(exp_err));
    end
    last_valid = ratio_valid;
    last_dd    = div_done;
    last_ratio = int'(ratio);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit dd;
    bit en;
    bit cv;
    int n;
    int k;

    #1;
    do_reset();

    // N=10, K=1/2: 10 after LOAD, then alternating 10, 11.
    step(0, 1, 1, 10, 'h8000);
    step(0, 1, 0, 0, 0);
    repeat (6) begin step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // N=10, K=1/4: every fourth update is 11.
    step(0, 1, 1, 10, 'h4000);
    step(0, 1, 0, 0, 0);
    repeat (9) begin step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); end

    // New config coincident with div_done: old config for that update, PEND blocks cfg.
    step(1, 1, 1, 20, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 50, 0);
    step(1, 1, 0, 0, 0);
    repeat (3) begin step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); end

    // Rejected configs (N < 2), alone and with div_done.
    step(0, 1, 1, 1, 'h1234);
    repeat (4) begin step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); end
    step(1, 1, 1, 0, 'h0100);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);

    // Config accepted while disabled is held until enable.
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 30, 'h5555);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (5) begin step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); end

    // Top of range: 255 + carry = 256; enable drop; reset mid-RUN.
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 255, 'hFFFF);
    step(0, 1, 0, 0, 0);
    repeat (4) begin step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); end
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 255, 'hFFFF);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    do_reset();
    repeat (3) step(1, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      dd = ($urandom_range(0, 2) == 0);
      en = ($urandom_range(0, 149) != 0);
      cv = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(0, 1));
      else n = int'($urandom_range(2, 255));
      case ($urandom_range(0, 5))
        0:       k = 0;
        1:       k = 'hFFFF;
        default: k = int'($urandom_range(0, 65535));
      endcase
      step(dd, en, cv, n, k);
    end

    repeat (3) step(0, 1, 0, 0, 0);
    check("ratio_queue_drained", exp_ratio_q.size(), 0);
    check("err_queue_drained", err_cyc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
